osc_trig_capture: RTL and testbench
===================================

# osc_trig_capture

Parametrised triggered-capture unit for the oscilloscope datapath. It takes a stream of samples, such as the ROM sine-table generator output or an ADC, and records them in a circular buffer. It detects a level/edge trigger and freezes a window that holds a programmable number of pre-trigger samples and the post-trigger samples. A 1-cycle-latency read port presents the window oldest-first to the display/readout logic.

## Interface
Parameters:
- DATA_W, 8, sample width (unsigned)
- DEPTH, 64, capture window length in samples; power of two, ≥ 4
- ADDR_W, $clog2(DEPTH), buffer index width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sample_valid  in  1  sample_data is a new sample this cycle
- sample_data  in  DATA_W  input sample
- arm  in  1  start a new capture (one-cycle pulse)
- trig_level  in  DATA_W  trigger threshold, unsigned compare
- trig_edge  in  1  0 = rising, 1 = falling
- pretrig  in  ADDR_W  samples kept before the trigger sample, 0..DEPTH-1; latched on arm
- force_trig  in  1  manual trigger request
- rd_addr  in  ADDR_W  window index, 0 = oldest sample
- rd_data  out  DATA_W  window sample, registered
- busy  out  1  capture in progress (PRE, WAIT_TRIG or POST)
- waiting  out  1  in WAIT_TRIG
- done  out  1  window frozen and readable

## Operation
- States: IDLE, PRE, WAIT_TRIG, POST, DONE. Reset puts the block in IDLE with all pointers/counters at 0 and rd_data, busy, waiting, done = 0.
- arm is accepted in any state and restarts the capture. On arm:
  - pretrig is latched (pre_q), the write pointer, counters, force latch and prev_valid are cleared, and done is cleared.
  - Next state is PRE if pre_q ≠ 0, otherwise WAIT_TRIG.
- Every sample with sample_valid in PRE, WAIT_TRIG or POST is written to mem[wr_ptr]. wr_ptr then increments mod DEPTH. No writes occur in IDLE or DONE.
- PRE: counts written samples and moves to WAIT_TRIG when the count reaches pre_q. Triggers are ignored in PRE, but prev is still tracked.
- Trigger qualification:
  - Evaluated only on a valid sample in WAIT_TRIG with prev_valid = 1.
  - prev is the last valid sample since arm.
  - Rising: prev < trig_level and cur ≥ trig_level.
  - Falling: prev ≥ trig_level and cur < trig_level.
- force_trig: a pulse in any busy state sets a latch. A set latch makes the next valid sample in WAIT_TRIG the trigger sample regardless of level/edge. The latch clears on trigger or arm.
- On trigger:
  - The trigger sample is written and counts as post sample 1.
  - start_ptr = (wr_ptr − pre_q) mod DEPTH, computed with the pre-increment wr_ptr.
  - Next state is POST.
- If DEPTH − pre_q = 1 (single post sample), the state goes directly to DONE.
- POST: after DEPTH − pre_q post samples in total have been written, the state goes to DONE.
- WAIT_TRIG overwrites the ring indefinitely. The pre-trigger region therefore always holds the pre_q most recent samples.
- DONE: the buffer is frozen, done = 1, and the state holds until arm.
- Read port: rd_data ← mem[(start_ptr + rd_addr) mod DEPTH] on every clk edge, in all states. Contents are defined only while done = 1.
- All pointer arithmetic is ADDR_W bits with natural wrap.

## Timing
- Write occurs on the edge where sample_valid = 1. State transitions caused by that sample take effect on the same edge.
- done rises on the edge that writes the last post sample. It is visible in the following cycle.
- busy rises on the edge that samples arm.
- rd_data latency: 1 cycle from rd_addr.
- Simultaneous events:
  - arm together with sample_valid: the arm wins and the sample is not written.
  - arm together with force_trig: the latch is cleared.
- rst_n low at any time asynchronously forces IDLE and zero outputs. Memory contents need not be cleared.

## Test plan
- Reset: assert rst_n = 0 mid-POST → busy, waiting, done, rd_data = 0 immediately. After release, no writes occur until arm.
- Rising trigger: DEPTH = 64, pretrig = 16, trig_level = 128, rising, ramp 0,1,…,255 one sample per clk after arm.
  - Trigger on sample 128; done after sample 175.
  - rd_addr 0 → 112, 16 → 128, 63 → 175.
- Falling trigger, pretrig = 0: sine 64×8 samples, trig_level = 128, falling.
  - rd_addr 0 holds the first sample < 128 that follows a sample ≥ 128.
  - 64 consecutive table samples follow.
- force_trig: constant input 0, pretrig = 8, force_trig pulsed 20 cycles after arm.
  - Trigger on the next valid sample; done after 56 further post samples in total.
  - Window holds all zeros; waiting never sees a level trigger.
- Gapped valid and trigger in PRE: sample_valid every 3rd cycle, ramp crossing the level during PRE.
  - The crossing is ignored and the next crossing is used.
  - Window is contiguous in sample order.
- Re-arm and boundaries: arm mid-POST → restart with done = 0, new window correct. pretrig = 63 → done on the trigger sample itself, rd_addr 63 = trigger sample.

Source files
------------

// File: rtl/osc_trig_capture.sv
// Triggered-capture unit: a circular sample buffer that freezes a window of
// pre-trigger and post-trigger samples around a level/edge or forced trigger,
// with a registered read port that presents the window oldest-first.
module osc_trig_capture #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic              force_trig,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              waiting,
  output logic              done
);

  // Counter needs one extra bit: a window with no pre-trigger samples has DEPTH post samples.
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pre_q, pre_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   start_ptr_q, start_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                force_q, force_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic [CNT_W-1:0]    post_total;
  logic                capturing;
  logic                wr_en;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Level crossing between the previous and current sample in the selected direction.
  function automatic logic edge_hit(input logic [DATA_W-1:0] prev,
                                    input logic [DATA_W-1:0] cur,
                                    input logic [DATA_W-1:0] level,
                                    input logic              falling);
    if (falling) return (prev >= level) && (cur < level);
    else         return (prev < level) && (cur >= level);
  endfunction

  assign capturing  = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign post_total = CNT_W'(DEPTH) - {1'b0, pre_q};

  // Next-state logic: arm restarts everything; otherwise each valid sample advances the capture.
  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    cnt_d       = cnt_q;
    force_d     = force_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    wr_en       = 1'b0;
    if (arm) begin
      pre_d      = pretrig;
      wr_ptr_d   = '0;
      cnt_d      = '0;
      force_d    = 1'b0;
      prev_vld_d = 1'b0;
      state_d    = (pretrig != '0) ? S_PRE : S_WAIT;
    end else if (capturing) begin
      if (force_trig) force_d = 1'b1;
      if (sample_valid) begin
        wr_en      = 1'b1;
        wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
        prev_d     = sample_data;
        prev_vld_d = 1'b1;
        case (state_q)
          S_PRE: begin
            if (cnt_q + CNT_W'(1) == {1'b0, pre_q}) begin
              cnt_d   = '0;
              state_d = S_WAIT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          S_WAIT: begin
            // A force latched on an earlier cycle claims this sample unconditionally.
            if (force_q || (prev_vld_q && edge_hit(prev_q, sample_data, trig_level, trig_edge))) begin
              start_ptr_d = wr_ptr_q - pre_q;
              force_d     = 1'b0;
              cnt_d       = CNT_W'(1);
              state_d     = (post_total == CNT_W'(1)) ? S_DONE : S_POST;
            end
          end
          S_POST: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) == post_total) state_d = S_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  // Control and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      cnt_q       <= '0;
      force_q     <= 1'b0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      wr_ptr_q    <= wr_ptr_d;
      start_ptr_q <= start_ptr_d;
      cnt_q       <= cnt_d;
      force_q     <= force_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
    end
  end

  // Sample ring; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= sample_data;
  end

  // Registered window read, rebased so index 0 is the oldest captured sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= mem[start_ptr_q + rd_addr];
  end

  assign rd_data = rd_data_q;
  assign busy    = capturing;
  assign waiting = (state_q == S_WAIT);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_osc_trig_capture.sv
// Bench for osc_trig_capture: table of short control vectors, directed
// multi-cycle scenarios, and randomized captures against a history-based model.
module tb_osc_trig_capture;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] sample_data = '0;
  logic              arm = 1'b0;
  logic [DATA_W-1:0] trig_level = 8'd128;
  logic              trig_edge = 1'b0;
  logic [ADDR_W-1:0] pretrig = '0;
  logic              force_trig = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              busy, waiting, done;

  int checks = 0;
  int errors = 0;

  osc_trig_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .arm(arm), .trig_level(trig_level), .trig_edge(trig_edge), .pretrig(pretrig),
    .force_trig(force_trig), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .waiting(waiting), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: the capture is the sample history since arm; the window
  // is the slice starting pre samples before the trigger sample.
  logic [7:0] hist[$];
  logic [7:0] mem_m [DEPTH];
  bit m_active = 0, m_done = 0, m_found = 0, m_pend = 0;
  int m_trig = 0, m_pre = 0, m_post = DEPTH;

  function automatic bit crosses(input int p, input int c, input int lvl, input bit fall);
    if (fall) return (p >= lvl) && (c < lvl);
    return (p < lvl) && (c >= lvl);
  endfunction

  function automatic bit m_busy();
    return m_active && !m_done;
  endfunction

  function automatic bit m_waiting();
    return m_active && !m_done && !m_found && (hist.size() >= m_pre);
  endfunction

  task automatic model_step();
    int k;
    if (arm) begin
      m_active = 1; m_done = 0; m_found = 0; m_pend = 0;
      hist.delete();
      m_pre = int'(pretrig); m_post = DEPTH - m_pre;
    end else if (m_active && !m_done) begin
      if (sample_valid) begin
        mem_m[hist.size() % DEPTH] = sample_data;
        hist.push_back(sample_data);
        k = hist.size() - 1;
        if (!m_found && k >= m_pre &&
            (m_pend || (k >= 1 && crosses(hist[k-1], hist[k], trig_level, trig_edge)))) begin
          m_found = 1; m_trig = k; m_pend = 0;
        end
        if (m_found && hist.size() == m_trig + m_post) m_done = 1;
      end
      if (force_trig && !m_found) m_pend = 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("busy", busy, m_busy());
    chk("waiting", waiting, m_waiting());
    chk("done", done, m_done);
  endtask

  task automatic do_arm(input int pre);
    pretrig = ADDR_W'(pre); arm = 1'b1; sample_valid = 1'b0;
    cycle();
    arm = 1'b0;
  endtask

  task automatic feed(input int d);
    sample_valid = 1'b1; sample_data = 8'(d);
    cycle();
    sample_valid = 1'b0;
  endtask

  task automatic read_one(input string name, input int a, input int exp);
    rd_addr = ADDR_W'(a);
    cycle();
    chk(name, rd_data, exp);
  endtask

  // Read the whole window while random samples arrive; the frozen buffer must ignore them.
  task automatic readout_all(input string name);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = ADDR_W'(a);
      sample_valid = 1'($urandom_range(0, 1));
      sample_data = 8'($urandom);
      cycle();
      chk(name, rd_data, hist[m_trig - m_pre + a]);
    end
    sample_valid = 1'b0;
  endtask

  typedef struct {
    bit arm; int pre; bit vld; int data; bit frc;
    bit e_busy; bit e_wait; bit e_done;
  } vec_t;

  vec_t vt[14];
  logic [7:0] sine[DEPTH];

  initial begin
    int n, f, cyc;
    // Reset state
    #12;
    chk("rst_busy", busy, 0); chk("rst_waiting", waiting, 0);
    chk("rst_done", done, 0); chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;

    // Short control vectors: arm, PRE count, rising trigger, arm-wins, force latch/clear
    vt[0]  = '{1, 2, 0,   0, 0, 1, 0, 0};
    vt[1]  = '{0, 2, 1, 200, 0, 1, 0, 0};
    vt[2]  = '{0, 2, 1, 100, 0, 1, 1, 0};
    vt[3]  = '{0, 2, 1,  50, 0, 1, 1, 0};
    vt[4]  = '{0, 2, 0,   0, 0, 1, 1, 0};
    vt[5]  = '{0, 2, 1, 150, 0, 1, 0, 0};
    vt[6]  = '{1, 0, 1,  77, 0, 1, 1, 0};
    vt[7]  = '{0, 0, 1, 200, 0, 1, 1, 0};
    vt[8]  = '{0, 0, 1,  10, 0, 1, 1, 0};
    vt[9]  = '{0, 0, 0,   0, 1, 1, 1, 0};
    vt[10] = '{0, 0, 1,   5, 0, 1, 0, 0};
    vt[11] = '{1, 0, 0,   0, 1, 1, 1, 0};
    vt[12] = '{0, 0, 1,   5, 0, 1, 1, 0};
    vt[13] = '{0, 0, 1,   0, 0, 1, 1, 0};
    trig_level = 8'd128; trig_edge = 1'b0;
    for (int i = 0; i < 14; i++) begin
      arm = vt[i].arm; pretrig = ADDR_W'(vt[i].pre); sample_valid = vt[i].vld;
      sample_data = 8'(vt[i].data); force_trig = vt[i].frc;
      cycle();
      arm = 1'b0; sample_valid = 1'b0; force_trig = 1'b0;
      chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("vec%0d_waiting", i), waiting, vt[i].e_wait);
      chk($sformatf("vec%0d_done", i), done, vt[i].e_done);
    end

    // Rising ramp, pretrig 16: trigger on 128, done after 175
    do_arm(16);
    for (n = 0; n < 256; n++) begin
      feed(n);
      if (n == 127) chk("ramp_wait_127", waiting, 1);
      if (n == 128) chk("ramp_wait_128", waiting, 0);
      if (n == 174) chk("ramp_done_174", done, 0);
      if (n == 175) begin chk("ramp_done_175", done, 1); break; end
    end
    read_one("ramp_rd0", 0, 112);
    read_one("ramp_rd16", 16, 128);
    read_one("ramp_rd63", 63, 175);
    readout_all("ramp_win");

    // Arm from DONE, then re-arm mid-POST with pretrig 63 (arm beats a simultaneous sample)
    do_arm(16);
    chk("rearm_done_clr", done, 0);
    for (n = 0; n <= 140; n++) feed(n);
    pretrig = 6'd63; arm = 1'b1; sample_valid = 1'b1; sample_data = 8'd141;
    cycle();
    arm = 1'b0; sample_valid = 1'b0;
    chk("rearm_busy", busy, 1); chk("rearm_done", done, 0); chk("rearm_waiting", waiting, 0);
    for (n = 0; n < 600 && !m_done; n++) feed((142 + n) % 256);
    chk("p63_last_sample", sample_data, 128);
    chk("p63_done", done, 1);
    read_one("p63_rd63", 63, 128);
    read_one("p63_rd0", 0, 65);
    readout_all("p63_win");

    // Falling sine, pretrig 0
    for (int i = 0; i < DEPTH; i++)
      sine[i] = 8'(int'(128.0 + 100.0 * $sin(2.0 * 3.14159265358979 * i / 64.0)));
    f = -1;
    for (int i = 1; i < DEPTH && f < 0; i++)
      if (sine[i] < 8'd128 && sine[i-1] >= 8'd128) f = i;
    trig_edge = 1'b1;
    do_arm(0);
    for (n = 0; n < 512 && !m_done; n++) feed(sine[n % DEPTH]);
    chk("sine_done", done, 1);
    read_one("sine_rd0", 0, sine[f]);
    read_one("sine_rd63", 63, sine[(f + 63) % DEPTH]);
    readout_all("sine_win");

    // force_trig on constant zero input, pretrig 8
    trig_edge = 1'b0;
    do_arm(8);
    for (n = 0; n < 19; n++) feed(0);
    chk("force_pre_waiting", waiting, 1);
    force_trig = 1'b1; cycle(); force_trig = 1'b0;
    for (n = 0; n < 200 && !m_done; n++) feed(0);
    chk("force_post_count", n, 56);
    chk("force_done", done, 1);
    for (int a = 0; a < DEPTH; a += 21) read_one("force_zero", a, 0);
    readout_all("force_win");

    // Gapped valid; crossing during PRE ignored, next one used
    do_arm(16);
    n = 0;
    for (cyc = 0; cyc < 600 && !m_done; cyc++) begin
      if (cyc % 3 == 2) begin feed(120 + n % 30); n++; end
      else cycle();
    end
    chk("gap_count", n, 86);
    read_one("gap_rd0", 0, 142);
    read_one("gap_rd16", 16, 128);
    readout_all("gap_win");

    // Asynchronous reset mid-POST; no writes in IDLE afterwards
    do_arm(16);
    for (n = 0; n <= 150; n++) feed(n);
    #2 rst_n = 1'b0;
    m_active = 0; m_done = 0;
    #1;
    chk("arst_busy", busy, 0); chk("arst_waiting", waiting, 0);
    chk("arst_done", done, 0); chk("arst_rd_data", rd_data, 0);
    #3 rst_n = 1'b1;
    rd_addr = '0;
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1; sample_data = 8'hAA;
      cycle();
      chk("idle_no_write", rd_data, mem_m[0]);
    end
    sample_valid = 1'b0;

    // Randomized captures
    for (int it = 0; it < 20; it++) begin
      trig_level = 8'($urandom); trig_edge = 1'($urandom);
      do_arm($urandom_range(0, DEPTH - 1));
      for (cyc = 0; cyc < 1200 && !m_done; cyc++) begin
        sample_valid = ($urandom_range(0, 3) != 0);
        sample_data = 8'($urandom);
        force_trig = ($urandom_range(0, 149) == 0);
        arm = ($urandom_range(0, 499) == 0);
        pretrig = 6'($urandom);
        cycle();
        arm = 1'b0; force_trig = 1'b0; sample_valid = 1'b0;
      end
      if (m_done) readout_all("rand_win");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
